sdram_pixel_prefetch: RTL and testbench

//  Read-side prefetch FIFO between the SDRAM facade and the VGA pixel pipeline.
//  - Issues burst read requests to the facade while the FIFO has room for a whole burst.
//  - Buffers returned pixels and serves them to the VGA side on demand with one-cycle latency.
//  - Flags underflow when the display pulls a pixel and the FIFO is empty.

---
 rtl/sdram_pixel_prefetch_if.sv | 52 +++++
 rtl/sdram_pixel_prefetch.sv | 155 +++++++++++++++
 tb/tb_sdram_pixel_prefetch.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pixel_prefetch_if.sv
// rtl/sdram_pixel_prefetch_if.sv - facade and VGA-side signal bundle for the pixel prefetch FIFO
// Optional feature macro: PREFETCH_UNDERFLOW_CNT_EN adds o_underflow_cnt.
interface sdram_pixel_prefetch_if #(
  parameter int PixelBitWidth = 16,
  parameter int FifoDepth     = 32
);
  logic                       o_read_req;
  logic                       i_busy_rd;
  logic                       i_ready;
  logic [PixelBitWidth-1:0]   i_pixel;
  logic                       i_pixel_req;
  logic                       i_frame_start;
  logic [PixelBitWidth-1:0]   o_pixel;
  logic                       o_valid;
  logic                       o_underflow;
  logic [$clog2(FifoDepth):0] o_level;
`ifdef PREFETCH_UNDERFLOW_CNT_EN
  logic [15:0]                o_underflow_cnt;
`endif

  modport slave (
`ifdef PREFETCH_UNDERFLOW_CNT_EN
    output o_underflow_cnt,
`endif
    output o_read_req,
    input  i_busy_rd,
    input  i_ready,
    input  i_pixel,
    input  i_pixel_req,
    input  i_frame_start,
    output o_pixel,
    output o_valid,
    output o_underflow,
    output o_level
  );

  modport master (
`ifdef PREFETCH_UNDERFLOW_CNT_EN
    input  o_underflow_cnt,
`endif
    input  o_read_req,
    output i_busy_rd,
    output i_ready,
    output i_pixel,
    output i_pixel_req,
    output i_frame_start,
    input  o_pixel,
    input  o_valid,
    input  o_underflow,
    input  o_level
  );
endinterface

// File: rtl/sdram_pixel_prefetch.sv
// rtl/sdram_pixel_prefetch.sv - burst-reserving read prefetch FIFO feeding the VGA pixel pipeline
// Optional feature macro: PREFETCH_UNDERFLOW_CNT_EN (saturating empty-pull counter).
module sdram_pixel_prefetch #(
  parameter int PixelBitWidth    = 16,
  parameter int FifoDepth        = 32,
  parameter int BurstLengthSDRAM = 8,
  parameter int TimeoutCycles    = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  sdram_pixel_prefetch_if.slave bus
);
  localparam int AW = $clog2(FifoDepth);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [LW-1:0]            r_wr_ptr;
  logic [LW-1:0]            r_rd_ptr;
  logic [LW-1:0]            r_reserved;
  logic [TW-1:0]            r_timer;
  logic [PixelBitWidth-1:0] r_mem [FifoDepth];
  logic [PixelBitWidth-1:0] r_pixel;
  logic                     r_valid;
  logic                     r_underflow;

  logic [LW-1:0]            w_level;
  logic [LW-1:0]            w_committed;
  logic                     w_room;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_empty_pull;
  logic                     w_timeout;

  // Occupancy plus pixels still owed must leave a whole burst of space.
  assign w_level      = r_wr_ptr - r_rd_ptr;
  assign w_committed  = w_level + r_reserved;
  assign w_room       = (w_committed <= LW'(FifoDepth - BurstLengthSDRAM));
  assign w_push       = (r_state == S_WAIT) && bus.i_ready;
  assign w_pop        = bus.i_pixel_req && (w_level != '0);
  assign w_empty_pull = bus.i_pixel_req && (w_level == '0);
  assign w_timeout    = (r_state == S_WAIT) && !bus.i_ready &&
                        (r_timer == TW'(TimeoutCycles - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_room && !bus.i_busy_rd) w_state_next = S_REQ;
      S_REQ:   w_state_next = S_WAIT;
      S_WAIT:  if ((w_push && (r_reserved == LW'(1))) || w_timeout) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_reserved <= '0;
      r_timer    <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          r_reserved <= LW'(BurstLengthSDRAM);
          r_timer    <= '0;
        end
        S_WAIT: begin
          if (w_push) begin
            r_reserved <= r_reserved - LW'(1);
            r_timer    <= '0;
          end else if (w_timeout) begin
            // Abort drops the remaining reservation; pixels already stored stay.
            r_reserved <= '0;
            r_timer    <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_reserved <= '0;
          r_timer    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.i_pixel;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pixel     <= '0;
      r_valid     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) r_pixel <= r_mem[r_rd_ptr[AW-1:0]];
      if (w_empty_pull) begin
        r_underflow <= 1'b1;
      end else if (bus.i_frame_start) begin
        r_underflow <= 1'b0;
      end
    end
  end

`ifdef PREFETCH_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_underflow_cnt <= '0;
    end else if (w_empty_pull) begin
      if (bus.i_frame_start) begin
        r_underflow_cnt <= 16'd1;
      end else if (r_underflow_cnt != 16'hFFFF) begin
        r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
    end else if (bus.i_frame_start) begin
      r_underflow_cnt <= '0;
    end
  end

  assign bus.o_underflow_cnt = r_underflow_cnt;
`endif

  assign bus.o_read_req  = (r_state == S_REQ);
  assign bus.o_pixel     = r_pixel;
  assign bus.o_valid     = r_valid;
  assign bus.o_underflow = r_underflow;
  assign bus.o_level     = w_level;
endmodule

// File: tb/tb_sdram_pixel_prefetch.sv
// tb/tb_sdram_pixel_prefetch.sv - table vectors, corner sequences and random traffic vs a queue model
// Honours PREFETCH_UNDERFLOW_CNT_EN when the design is built with it.
module tb_sdram_pixel_prefetch;
  localparam int PW = 16;
  localparam int FD = 32;
  localparam int BL = 8;
  localparam int TO = 64;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sdram_pixel_prefetch_if #(.PixelBitWidth(PW), .FifoDepth(FD)) bus ();

  sdram_pixel_prefetch #(
    .PixelBitWidth(PW), .FifoDepth(FD), .BurstLengthSDRAM(BL), .TimeoutCycles(TO)
  ) u_dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic        rdy;
    logic [15:0] px;
    logic        req;
    logic        fs;
    logic        exp_valid;
    logic [15:0] exp_pixel;
    int          exp_level;
    logic        exp_under;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_req = 0;
  int          owed  = 0;
  int          idle  = 0;
  int          m_cnt = 0;
  logic [15:0] mq[$];
  logic        m_valid = 1'b0;
  logic        m_under = 1'b0;
  logic [15:0] m_pixel = '0;
  bit          last_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_pixel = '0;
    m_under = 1'b0;
    m_cnt   = 0;
    owed    = 0;
    idle    = 0;
  endtask

  task automatic drive(input logic rdy, input logic [15:0] px, input logic req,
                       input logic fs, input logic busy);
    bus.i_ready       = rdy;
    bus.i_pixel       = px;
    bus.i_pixel_req   = req;
    bus.i_frame_start = fs;
    bus.i_busy_rd     = busy;
  endtask

  // One clock: compare outputs against the model, drive inputs, advance the model over the edge.
  task automatic step(input logic rdy, input logic [15:0] px, input logic req,
                      input logic fs, input logic busy);
    bit push;
    bit pop;
    bit empty_pull;
    @(negedge CLK);
    check("level", 32'(bus.o_level), 32'(mq.size()));
    check("valid", 32'(bus.o_valid), 32'(m_valid));
    check("pixel", 32'(bus.o_pixel), 32'(m_pixel));
    check("underflow", 32'(bus.o_underflow), 32'(m_under));
`ifdef PREFETCH_UNDERFLOW_CNT_EN
    check("underflow_cnt", 32'(bus.o_underflow_cnt), 32'(m_cnt));
`endif
    last_req = bus.o_read_req;
    if (last_req) begin
      n_req++;
      check("req_legal", 32'(owed == 0 && (FD - mq.size()) >= BL), 32'd1);
    end
    drive(rdy, px, req, fs, busy);
    push       = rdy && (owed > 0);
    pop        = req && (mq.size() > 0);
    empty_pull = req && (mq.size() == 0);
    m_valid = pop;
    if (pop) m_pixel = mq.pop_front();
    if (push) mq.push_back(px);
    if (empty_pull) m_under = 1'b1;
    else if (fs)    m_under = 1'b0;
    if (empty_pull) m_cnt = fs ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
    else if (fs)    m_cnt = 0;
    if (push) begin
      owed--;
      idle = 0;
    end else if (owed > 0) begin
      idle++;
      if (idle == TO) begin
        owed = 0;
        idle = 0;
      end
    end
    if (last_req) begin
      owed = BL;
      idle = 0;
    end
  endtask

  task automatic wait_req(input int maxc, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      if (last_req) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    check("rst_read_req", 32'(bus.o_read_req), 32'd0);
    check("rst_level", 32'(bus.o_level), 32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_pixel", 32'(bus.o_pixel), 32'd0);
    check("rst_underflow", 32'(bus.o_underflow), 32'd0);
    RST = 1'b1;
    model_reset();
  endtask

  initial begin
    int          first_req;
    int          req0;
    int          pv;
    logic        rdy;
    logic        req;
    logic        fs;
    logic        busy;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Idle facade: one request per timeout period, exactly 4 in 264 cycles.
    do_reset();
    first_req = -1;
    for (int i = 1; i <= 264; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      if (last_req && first_req < 0) first_req = i;
    end
    check("first_req_within_2", 32'(first_req >= 1 && first_req <= 2), 32'd1);
    check("req_count_264", 32'(n_req), 32'd4);

    // Table: fill 0x0001..0x0008, drain in order, then underflow / frame_start rules.
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{1'b1, 16'(k), 1'b0, 1'b0, 1'b0, 16'h0, k, 1'b0});
    for (int k = 1; k <= 8; k++)
      tbl.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'(k), 8 - k, 1'b0});
    tbl.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h8, 0, 1'b1});
    tbl.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h8, 0, 1'b1});
    tbl.push_back('{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h8, 0, 1'b0});
    tbl.push_back('{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h8, 0, 1'b1});
    tbl.push_back('{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h8, 0, 1'b0});
    do_reset();
    wait_req(3, "tbl_req");
    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].px, tbl[i].req, tbl[i].fs, 1'b1);
      @(posedge CLK);
      #1;
      check($sformatf("tbl%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_pixel", i), 32'(bus.o_pixel), 32'(tbl[i].exp_pixel));
      check($sformatf("tbl%0d_level", i), 32'(bus.o_level), 32'(tbl[i].exp_level));
      check($sformatf("tbl%0d_under", i), 32'(bus.o_underflow), 32'(tbl[i].exp_under));
    end
`ifdef PREFETCH_UNDERFLOW_CNT_EN
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    check("cnt_after_3", 32'(bus.o_underflow_cnt), 32'd3);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    @(posedge CLK);
    #1;
    check("cnt_cleared", 32'(bus.o_underflow_cnt), 32'd0);
    check("under_cleared", 32'(bus.o_underflow), 32'd0);
`endif

    // Level 24 with a burst outstanding: no request until that burst lands.
    do_reset();
    pv = 1;
    for (int b = 0; b < 3; b++) begin
      wait_req(4, "fill_req");
      repeat (BL) begin
        step(1'b1, 16'(pv), 1'b0, 1'b0, 1'b0);
        pv++;
      end
    end
    wait_req(4, "req_at_24");
    req0 = n_req;
    repeat (BL) step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("no_req_while_owed", 32'(n_req - req0), 32'd0);
    repeat (BL) begin
      step(1'b1, 16'(pv), 1'b0, 1'b0, 1'b0);
      pv++;
    end
    wait_req(3, "req_after_burst");
    repeat (BL) begin
      step(1'b1, 16'(pv), 1'b0, 1'b0, 1'b0);
      pv++;
    end
    req0 = n_req;
    repeat (6) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("full_level", 32'(bus.o_level), 32'(FD));
    check("no_req_when_full", 32'(n_req - req0), 32'd0);

    // Timeout after 3 of 8 pixels: back to idle, stray i_ready ignored, re-request when not busy.
    do_reset();
    wait_req(3, "to_req");
    for (int k = 0; k < 3; k++) step(1'b1, 16'hA0 + 16'(k), 1'b0, 1'b0, 1'b1);
    req0 = n_req;
    repeat (TO) step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("to_level", 32'(bus.o_level), 32'd3);
    check("to_no_req_busy", 32'(n_req - req0), 32'd0);
    wait_req(3, "to_rereq");

    // Reset mid-burst clears everything at once; no stale pixels afterwards.
    do_reset();
    wait_req(3, "mid_req");
    for (int k = 0; k < 3; k++) step(1'b1, 16'h55 + 16'(k), 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_read_req", 32'(bus.o_read_req), 32'd0);
    check("mid_rst_level", 32'(bus.o_level), 32'd0);
    check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    check("mid_rst_pixel", 32'(bus.o_pixel), 32'd0);
    check("mid_rst_under", 32'(bus.o_underflow), 32'd0);
    @(negedge CLK);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    model_reset();
    wait_req(2, "mid_rereq");
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      busy = ($urandom_range(3) == 0);
      rdy  = (owed > 0) && ($urandom_range(9) < 7);
      req  = ($urandom_range(9) < 4);
      fs   = ($urandom_range(99) < 3);
      step(rdy, 16'($urandom), req, fs, busy);
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
